// File: rtl/truth_table_sequencer.sv
// Sweeps every input row of a combinational block, waits a settle time per row, and
// records the results in a row-indexed table with a registered readback port.
//
// state    | meaning
// S_IDLE   | waiting for start after reset
// S_APPLY  | drive {w,x,y,z} from row, load settle counter
// S_SETTLE | count down SETTLE cycles while the block settles
// S_SAMPLE | capture r_in into table, pulse row_valid, advance or finish
// S_DONE   | sweep complete, done held until next start or rst
module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 6,
  parameter int SETTLE = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             w,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic [N_OUT-1:0] r_in,
  output logic [N_IN:0]    row,
  output logic             row_valid,
  output logic [N_OUT-1:0] row_data,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data
);

  localparam int            ROWS = 1 << N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(ROWS - 1);
  localparam logic [N_IN:0] ONE  = (N_IN+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [ROWS-1:0]  valid;
  logic [N_OUT-1:0] table_mem [ROWS];

  // Table contents are deliberately not reset; the valid bits gate readback instead.
  always_ff @(posedge clk) begin
    if (!rst && state == S_SAMPLE)
      table_mem[row[N_IN-1:0]] <= r_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      valid     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      row       <= '0;
      {w, x, y, z} <= 4'b0000;
      row_valid <= 1'b0;
      row_data  <= '0;
      rd_data   <= '0;
    end else begin
      row_valid <= 1'b0;
      rd_data   <= valid[rd_addr] ? table_mem[rd_addr] : '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_APPLY;
            row   <= '0;
            valid <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_APPLY: begin
          {w, x, y, z} <= row[3:0];
          cnt          <= 8'(SETTLE - 1);
          state        <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == 8'd0) state <= S_SAMPLE;
          else             cnt   <= cnt - 8'd1;
        end
        S_SAMPLE: begin
          valid[row[N_IN-1:0]] <= 1'b1;
          row_valid <= 1'b1;
          row_data  <= r_in;
          // Equality compare on the last row; row never wraps past it.
          if (row == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            row   <= row + ONE;
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized-table bench: instance 0 uses the default settle time, instance 1 uses SETTLE=1.
// Expected timing and data come from row-period arithmetic over a random truth table.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [2];
  logic       start_a [2];
  logic       busy_a [2];
  logic       done_a [2];
  logic       w_a [2];
  logic       x_a [2];
  logic       y_a [2];
  logic       z_a [2];
  logic       rv_a [2];
  logic [5:0] r_in_a [2];
  logic [5:0] row_data_a [2];
  logic [5:0] rd_data_a [2];
  logic [4:0] row_a [2];
  logic [3:0] rd_addr_a [2];

  logic [5:0] tt [16];
  logic       hold;

  int n_tests = 0;
  int n_fail  = 0;

  assign r_in_a[0] = hold ? 6'h2A : tt[{w_a[0], x_a[0], y_a[0], z_a[0]}];
  assign r_in_a[1] = hold ? 6'h2A : tt[{w_a[1], x_a[1], y_a[1], z_a[1]}];

  truth_table_sequencer #(.N_IN(4), .N_OUT(6), .SETTLE(12)) u_seq0 (
    .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .w(w_a[0]), .x(x_a[0]), .y(y_a[0]), .z(z_a[0]), .r_in(r_in_a[0]), .row(row_a[0]),
    .row_valid(rv_a[0]), .row_data(row_data_a[0]), .rd_addr(rd_addr_a[0]), .rd_data(rd_data_a[0])
  );

  truth_table_sequencer #(.N_IN(4), .N_OUT(6), .SETTLE(1)) u_seq1 (
    .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .w(w_a[1]), .x(x_a[1]), .y(y_a[1]), .z(z_a[1]), .r_in(r_in_a[1]), .row(row_a[1]),
    .row_valid(rv_a[1]), .row_data(row_data_a[1]), .rd_addr(rd_addr_a[1]), .rd_data(rd_data_a[1])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int wxyz(input int d);
    return int'({w_a[d], x_a[d], y_a[d], z_a[d]});
  endfunction

  task automatic check_idle_reset(input int d);
    chk("rst_busy", busy_a[d], 0);
    chk("rst_done", done_a[d], 0);
    chk("rst_row", row_a[d], 0);
    chk("rst_wxyz", wxyz(d), 0);
    chk("rst_row_valid", rv_a[d], 0);
    chk("rst_row_data", row_data_a[d], 0);
    chk("rst_rd_data", rd_data_a[d], 0);
  endtask

  // p is the row period (settle + 2); restart_cyc / rst_cyc < 0 disables those events.
  task automatic sweep(input int d, input int p, input int restart_cyc, input int rst_cyc);
    int pulses = 0;
    int exp_data;
    @(negedge clk); start_a[d] = 1'b1;
    @(negedge clk); start_a[d] = 1'b0;
    chk("busy_after_start", busy_a[d], 1);
    for (int cyc = 1; cyc <= 16 * p; cyc++) begin
      @(negedge clk);
      start_a[d] = (cyc == restart_cyc);
      chk("wxyz", wxyz(d), (cyc - 1) / p);
      chk("row_le_15", int'(row_a[d] <= 5'd15), 1);
      chk("row_valid", rv_a[d], int'((cyc % p) == 0));
      if (rv_a[d]) begin
        pulses++;
        exp_data = hold ? 32'h2A : int'(tt[cyc / p - 1]);
        chk("row_data", row_data_a[d], exp_data);
      end
      chk("busy", busy_a[d], int'(cyc < 16 * p));
      chk("done", done_a[d], int'(cyc == 16 * p));
      if (cyc == rst_cyc) begin
        chk("row_at_rst", row_a[d], 9);
        rst_a[d] = 1'b1;
        @(negedge clk);
        rst_a[d] = 1'b0;
        check_idle_reset(d);
        rd_addr_a[d] = 4'd3;
        @(negedge clk);
        chk("rd3_after_rst", rd_data_a[d], 0);
        @(negedge clk);
        chk("idle_after_rst", busy_a[d], 0);
        return;
      end
    end
    start_a[d] = 1'b0;
    chk("pulses", pulses, 16);
    chk("row_final", row_a[d], 15);
    @(negedge clk);
    chk("done_sticky", done_a[d], 1);
    chk("wxyz_hold", wxyz(d), 15);
  endtask

  task automatic readback(input int d);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk); rd_addr_a[d] = 4'(a);
      @(negedge clk);
      chk("rd_data", rd_data_a[d], tt[a]);
      if (a == 0)  chk("rd0_const", rd_data_a[d], 6'b100101);
      if (a == 15) chk("rd15_const", rd_data_a[d], 6'b110101);
    end
  endtask

  initial begin
    hold = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1'b1; start_a[d] = 1'b0; rd_addr_a[d] = 4'd0;
    end
    for (int i = 0; i < 16; i++) tt[i] = 6'($urandom_range(0, 63));
    tt[0]  = 6'b100101;
    tt[15] = 6'b110101;

    repeat (3) @(negedge clk);
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    @(negedge clk);
    check_idle_reset(0);
    check_idle_reset(1);
    rd_addr_a[0] = 4'd5;
    @(negedge clk);
    chk("rd_before_sweep", rd_data_a[0], 0);

    sweep(0, 14, -1, -1);
    readback(0);

    hold = 1'b1;
    sweep(0, 14, -1, -1);
    hold = 1'b0;

    sweep(0, 14, 5 * 14 + 3, -1);
    readback(0);

    sweep(0, 14, -1, 9 * 14 + 3);

    for (int i = 1; i < 15; i++) tt[i] = 6'($urandom_range(0, 63));
    sweep(1, 3, -1, -1);
    readback(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
